instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Sequential instruction-fetch stage that sits directly upstream of the main controller and datapath. It holds the PC and fetches 32-bit words from a variable-latency instruction memory over a req/valid handshake. It presents the latched instruction, with `op`/`func3`/`func7` sliced out for the controller, to the execute stage under a valid/ready handshake. It applies the controller's `PCSrc` and `done` outcomes to select the next PC or halt.

## Interface
- `XLEN`, 32, data/address width
- `RESET_PC`, 32'h0000_0000, PC loaded on reset (word aligned)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_req`  out  1  fetch request, held high until `imem_valid`
- `imem_addr`  out  XLEN  fetch address (= PC), stable while `imem_req`
- `imem_rdata`  in  32  fetched word, sampled when `imem_valid`
- `imem_valid`  in  1  read data valid; only meaningful while `imem_req` is high
- `instr`  out  32  latched instruction register (IR)
- `op`  out  7  IR[6:0]
- `func3`  out  3  IR[14:12]
- `func7`  out  7  IR[31:25]
- `pc`  out  XLEN  address of `instr`
- `pc_plus4`  out  XLEN  `pc + 4`, for jal/jalr link
- `instr_valid`  out  1  `instr` is valid for execute
- `instr_ready`  in  1  execute consumes `instr` this cycle
- `pc_src`  in  1  controller `PCSrc` for the current instruction
- `pc_target`  in  XLEN  branch/jal/jalr target from the datapath
- `done`  in  1  controller `done` for the current instruction
- `halted`  out  1  sticky halt indication
- `instr_count`  out  32  number of accepted (retired) instructions

## Operation
- States are IDLE, FETCH, ISSUE and HALT.
- Reset takes priority over all other inputs in any state. It produces: state=IDLE, PC=`RESET_PC`, IR=0, `instr_count`=0, and all outputs low except `pc`=`RESET_PC` and `pc_plus4`=`RESET_PC+4`.
- IDLE lasts one cycle with `imem_req`=0, then moves to FETCH. This guarantees that any pre-reset request is cancelled.
- FETCH drives `imem_req`=1 and `imem_addr`=PC.
  - On a cycle with `imem_valid`=1, IR←`imem_rdata` and the state moves to ISSUE.
  - Otherwise the unit stays in FETCH; there is no timeout.
- ISSUE drives `instr_valid`=1 and holds IR and PC stable.
  - If `instr_ready`=0, the unit stays in ISSUE. `pc_src`, `pc_target` and `done` are ignored.
  - On `instr_ready`=1, `instr_count`←`instr_count`+1 (wraps modulo 2^32).
  - Then, if `done`=1: state→HALT and the PC is unchanged.
  - Else: PC←`pc_src` ? {`pc_target`[XLEN-1:2],2'b00} : PC+4 (wraps modulo 2^XLEN), and state→FETCH.
- HALT is sticky until `rst`. In HALT: `halted`=1, `instr_valid`=0, `imem_req`=0, and `imem_valid` is ignored.
- The memory contract is as follows:
  - Memory responds only while `imem_req` is high.
  - Deasserting `imem_req` cancels any pending access.
  - Zero-wait memory may assert `imem_valid` in the same cycle as `imem_req` rises.

## Timing
- `op`, `func3`, `func7`, `pc` and `pc_plus4` are combinational slices of the registered IR and PC. No input-to-output combinational path exists.
- `instr_valid`, `imem_req` and `halted` are decoded from the state register only.
- After `rst` deasserts:
  - Cycle 0 is IDLE.
  - Cycle 1 is FETCH with `imem_req`=1.
  - With zero-wait memory, `instr_valid` first rises at cycle 2.
- With zero-wait memory and `instr_ready` held high, steady-state throughput is one instruction per 2 cycles. Each memory wait cycle adds one cycle.
- The new PC is visible on `imem_addr` in the cycle after the accepting ISSUE cycle.
- `pc_target` and `pc_src` are sampled only at the accepting edge.
- `halted` rises in the cycle after the accepting edge of a `done` instruction.
- `rst` asserted mid-FETCH or mid-ISSUE: at the next edge the state is IDLE and the pending instruction is dropped without counting.

## Structure
- Place the opcode constants and the fetch-state encoding (IDLE=2'b00, FETCH=2'b01, ISSUE=2'b10, HALT=2'b11) in the shared `riscv_defs` header. The opcode constants are `lw`, `sw`, `RT`, `BT`, `IT`, `jalr`, `jal` and `lui`; the controller also includes this header.
- One sub-module, `fetch_pc_reg`, is natural:
  - It holds the PC register with a synchronous reset to `RESET_PC`, a load enable, and the next-PC mux including alignment.
  - It outputs `pc` and `pc_plus4`.
- The FSM, IR and counter live in the top module.

## Test plan
- Reset and sequential fetch:
  - Stimulus: zero-wait memory returning `addi` (32'h0010_0093) at 0x0, 0x4 and 0x8; `instr_ready`=1; `pc_src`=0; `done`=0.
  - Required response: `imem_addr` = 0x0, 0x4, 0x8; `instr_valid` on cycles 2, 4 and 6; `op`=7'b0010011; `instr_count`=3 after the third acceptance.
- Memory wait states:
  - Stimulus: `imem_valid` delayed 3 cycles.
  - Required response: `imem_req` and `imem_addr` stay stable for 4 cycles; IR loads only on the valid cycle; `instr_valid` follows one cycle later.
- Back-pressure:
  - Stimulus: `instr_ready`=0 for 5 cycles in ISSUE, with `pc_src`/`pc_target` toggling.
  - Required response: `instr`/`pc` unchanged; no fetch issued; `instr_count` unchanged; the next PC uses only the values present at the accepting edge.
- Branch taken with alignment:
  - Stimulus: `pc_src`=1 and `pc_target`=0x0000_0103 at acceptance.
  - Required response: next `imem_addr`=0x0000_0100.
- PC wrap-around:
  - Stimulus: `RESET_PC`=32'hFFFF_FFFC and sequential execution.
  - Required response: the second fetch address is 0x0000_0000.
- Halt and reset mid-operation:
  - Stimulus: `done`=1 on the accepted instruction at PC 0x8.
  - Required response: `halted`=1 next cycle and `imem_req` stays 0 for 20 cycles.
  - Stimulus: `rst` asserted during a subsequent FETCH.
  - Required response: IDLE next cycle, PC=`RESET_PC`, and `imem_valid` asserted in the IDLE cycle is ignored.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared RISC-V definitions: base opcodes and the fetch-state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package instr_fetch_unit_pkg;

    // Base-ISA major opcodes (instr[6:0]), shared with the main controller.
    localparam logic [6:0] lw   = 7'b0000011;
    localparam logic [6:0] sw   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] BT   = 7'b1100011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] jalr = 7'b1100111;
    localparam logic [6:0] jal  = 7'b1101111;
    localparam logic [6:0] lui  = 7'b0110111;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        ISSUE = 2'b10,
        HALT  = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory port, issue handshake and controller feedback.
// Latency: n/a (wiring only).
// Backpressure: instr_valid/instr_ready on the issue side; imem_req/imem_valid on memory side.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_valid;
    logic [31:0]     instr;
    logic [6:0]      op;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            instr_valid;
    logic            instr_ready;
    logic            pc_src;
    logic [XLEN-1:0] pc_target;
    logic            done;
    logic            halted;
    logic [31:0]     instr_count;

    // Fetch unit side.
    modport master (
        output imem_req, imem_addr, instr, op, func3, func7, pc, pc_plus4,
               instr_valid, halted, instr_count,
        input  imem_rdata, imem_valid, instr_ready, pc_src, pc_target, done
    );

    // Memory / controller / datapath side.
    modport slave (
        input  imem_req, imem_addr, instr, op, func3, func7, pc, pc_plus4,
               instr_valid, halted, instr_count,
        output imem_rdata, imem_valid, instr_ready, pc_src, pc_target, done
    );
endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// PC register with next-PC select (sequential or word-aligned target).
// Latency: new PC visible one cycle after load.
// Backpressure: none; PC holds whenever load is low.
module fetch_pc_reg #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;

    // Next PC: taken target forced to a word boundary, else fall-through (wraps).
    always_comb begin
        pc_next = pc_q + XLEN'(4);
        if (pc_src) begin
            pc_next = {pc_target[XLEN-1:2], 2'b00};
        end
    end

    // PC register, updated only on a retiring non-halting instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (load) begin
            pc_q <= pc_next;
        end
    end

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + XLEN'(4);
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: fetches from variable-latency imem, issues IR to execute, applies PCSrc/done.
// Latency: zero-wait fetch gives instr_valid 1 cycle after request; 2 cycles per instruction.
// Backpressure: holds IR/PC in ISSUE while instr_ready is low; imem_req held until imem_valid.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);
    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [31:0]     ir_q;
    logic [31:0]     count_q;
    logic [XLEN-1:0] pc;
    logic            accept;
    logic            pc_load;

    assign accept  = (state_q == ISSUE) && bus.instr_ready;
    assign pc_load = accept && !bus.done;

    // State register; reset always returns to IDLE so a stale request is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE is a single cycle, HALT is sticky until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (bus.imem_valid) state_d = ISSUE;
            ISSUE:   if (bus.instr_ready) state_d = bus.done ? HALT : FETCH;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // Instruction register, loaded only on the cycle memory returns data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q <= '0;
        end else if ((state_q == FETCH) && bus.imem_valid) begin
            ir_q <= bus.imem_rdata;
        end
    end

    // Retired-instruction counter, free-running wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + 32'd1;
        end
    end

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (pc_load),
        .pc_src    (bus.pc_src),
        .pc_target (bus.pc_target),
        .pc        (pc),
        .pc_plus4  (bus.pc_plus4)
    );

    // Handshake outputs are pure state decodes; no input reaches an output combinationally.
    assign bus.imem_req    = (state_q == FETCH);
    assign bus.instr_valid = (state_q == ISSUE);
    assign bus.halted      = (state_q == HALT);
    assign bus.imem_addr   = bus.imem_req ? pc : '0;
    assign bus.pc          = pc;
    assign bus.instr       = ir_q;
    assign bus.op          = ir_q[6:0];
    assign bus.func3       = ir_q[14:12];
    assign bus.func7       = ir_q[31:25];
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a transaction-level reference model.
// Latency: n/a.
// Backpressure: exercised with randomized instr_ready stalls and memory wait states.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.XLEN(32)) m_if ();
    instr_fetch_unit_if #(.XLEN(32)) w_if ();

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk), .rst (rst), .bus (m_if.master)
    );

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk (clk), .rst (rst), .bus (w_if.master)
    );

    // Wrap instance: zero-wait memory, always ready, purely sequential.
    assign w_if.imem_valid  = w_if.imem_req;
    assign w_if.imem_rdata  = 32'h0010_0093;
    assign w_if.instr_ready = 1'b1;
    assign w_if.pc_src      = 1'b0;
    assign w_if.pc_target   = 32'h0;
    assign w_if.done        = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] m_pc, m_ir, m_count;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_ir    = 32'h0;
        m_count = 32'h0;
    endtask

    task automatic chk_reset_state();
        chk1("rst_req", m_if.imem_req, 1'b0);
        chk1("rst_ivld", m_if.instr_valid, 1'b0);
        chk1("rst_halted", m_if.halted, 1'b0);
        chk("rst_instr", m_if.instr, 32'h0);
        chk("rst_pc", m_if.pc, 32'h0);
        chk("rst_pc4", m_if.pc_plus4, 32'h4);
        chk("rst_count", m_if.instr_count, 32'h0);
        chk("rst_addr", m_if.imem_addr, 32'h0);
    endtask

    // Fetch phase: request must stay up with a stable address until the memory answers.
    task automatic do_fetch(input int waits, input logic [31:0] word);
        for (int w = 0; w <= waits; w++) begin
            chk1("fetch_req", m_if.imem_req, 1'b1);
            chk("fetch_addr", m_if.imem_addr, m_pc);
            chk1("fetch_ivld", m_if.instr_valid, 1'b0);
            chk("fetch_ir_hold", m_if.instr, m_ir);
            m_if.imem_valid = (w == waits);
            m_if.imem_rdata = (w == waits) ? word : $urandom;
            step();
        end
        m_if.imem_valid = 1'b0;
        m_ir = word;
    endtask

    // Issue phase: outputs held through stalls; only the accepting cycle's controls matter.
    task automatic do_issue(input int stalls, input logic src, input logic [31:0] tgt,
                            input logic dn);
        for (int s = 0; s <= stalls; s++) begin
            chk1("issue_ivld", m_if.instr_valid, 1'b1);
            chk1("issue_req", m_if.imem_req, 1'b0);
            chk1("issue_halted", m_if.halted, 1'b0);
            chk("issue_instr", m_if.instr, m_ir);
            chk("issue_op", 32'(m_if.op), 32'(m_ir[6:0]));
            chk("issue_f3", 32'(m_if.func3), 32'(m_ir[14:12]));
            chk("issue_f7", 32'(m_if.func7), 32'(m_ir[31:25]));
            chk("issue_pc", m_if.pc, m_pc);
            chk("issue_pc4", m_if.pc_plus4, m_pc + 32'd4);
            chk("issue_count", m_if.instr_count, m_count);
            if (s < stalls) begin
                m_if.instr_ready = 1'b0;
                m_if.pc_src      = 1'($urandom_range(0, 1));
                m_if.pc_target   = $urandom;
                m_if.done        = 1'($urandom_range(0, 1));
            end else begin
                m_if.instr_ready = 1'b1;
                m_if.pc_src      = src;
                m_if.pc_target   = tgt;
                m_if.done        = dn;
            end
            step();
        end
        m_if.instr_ready = 1'b0;
        m_if.pc_src      = 1'b0;
        m_if.done        = 1'b0;
        m_if.pc_target   = $urandom;
        m_count = m_count + 32'd1;
        if (dn) begin
            chk1("halt_rise", m_if.halted, 1'b1);
            chk1("halt_ivld", m_if.instr_valid, 1'b0);
            chk1("halt_req", m_if.imem_req, 1'b0);
        end else if (src) begin
            m_pc = {tgt[31:2], 2'b00};
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        rst = 1'b1;
        m_if.imem_valid  = 1'b0;
        m_if.imem_rdata  = 32'h0;
        m_if.instr_ready = 1'b0;
        m_if.pc_src      = 1'b0;
        m_if.pc_target   = 32'h0;
        m_if.done        = 1'b0;
        model_reset();
        repeat (3) step();
        chk_reset_state();
        chk("wrap_rst_pc", w_if.pc, 32'hFFFF_FFFC);
        chk("wrap_rst_pc4", w_if.pc_plus4, 32'h0000_0000);

        // Cycle 0 after release: IDLE, a stray imem_valid must be ignored.
        rst = 1'b0;
        cyc = 0;
        chk1("idle_req", m_if.imem_req, 1'b0);
        m_if.imem_valid = 1'b1;
        m_if.imem_rdata = 32'hDEAD_BEEF;
        step();
        m_if.imem_valid = 1'b0;
        chk1("wrap_req1", w_if.imem_req, 1'b1);
        chk("wrap_addr1", w_if.imem_addr, 32'hFFFF_FFFC);

        // Three sequential addi with zero-wait memory; issue on cycles 2, 4, 6.
        for (int k = 0; k < 3; k++) begin
            do_fetch(0, 32'h0010_0093);
            chk("issue_cycle", cyc, 2 * k + 2);
            chk("addi_op", 32'(m_if.op), 32'h13);
            do_issue(0, 1'b0, 32'h0, 1'b0);
            if (k == 0) begin
                chk1("wrap_req2", w_if.imem_req, 1'b1);
                chk("wrap_addr2", w_if.imem_addr, 32'h0000_0000);
            end
        end
        chk("count_after3", m_if.instr_count, 32'd3);

        // Memory wait states, back-pressure, then an unaligned taken branch.
        do_fetch(3, 32'h0020_8133);
        do_issue(0, 1'b0, 32'h0, 1'b0);
        do_fetch(0, 32'h4030_5213);
        do_issue(5, 1'b0, 32'h0, 1'b0);
        do_fetch(0, 32'hFE20_8EE3);
        do_issue(0, 1'b1, 32'h0000_0103, 1'b0);
        chk("branch_addr", m_if.imem_addr, 32'h0000_0100);

        // Randomized mix of waits, stalls and taken targets.
        for (int n = 0; n < 30; n++) begin
            do_fetch($urandom_range(0, 3), $urandom);
            do_issue($urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom, 1'b0);
        end

        // Reset mid-ISSUE while ready is high: instruction dropped uncounted.
        do_fetch(0, $urandom);
        chk1("pre_rst_ivld", m_if.instr_valid, 1'b1);
        m_if.instr_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_if.instr_ready = 1'b0;
        model_reset();
        chk_reset_state();
        m_if.imem_valid = 1'b1;
        m_if.imem_rdata = $urandom;
        step();
        m_if.imem_valid = 1'b0;

        // Halt on the instruction at PC 0x8.
        do_fetch(0, $urandom);
        do_issue(0, 1'b0, 32'h0, 1'b0);
        do_fetch(1, $urandom);
        do_issue(1, 1'b0, 32'h0, 1'b0);
        do_fetch(0, 32'h0000_0073);
        chk("halt_at_pc", m_if.pc, 32'h8);
        do_issue(2, 1'b0, 32'h0, 1'b1);
        for (int h = 0; h < 20; h++) begin
            chk1("halt_req_low", m_if.imem_req, 1'b0);
            chk1("halt_sticky", m_if.halted, 1'b1);
            chk1("halt_no_ivld", m_if.instr_valid, 1'b0);
            chk("halt_pc_hold", m_if.pc, m_pc);
            chk("halt_ir_hold", m_if.instr, m_ir);
            chk("halt_count", m_if.instr_count, m_count);
            m_if.imem_valid = 1'b1;
            m_if.imem_rdata = $urandom;
            step();
        end
        m_if.imem_valid = 1'b0;

        // Leave HALT, then reset again in the middle of a fetch.
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        chk_reset_state();
        step();
        chk1("mid_fetch_req", m_if.imem_req, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_state();
        m_if.imem_valid = 1'b1;
        m_if.imem_rdata = 32'hBAD0_BAD0;
        step();
        m_if.imem_valid = 1'b0;
        do_fetch(0, 32'h0050_0293);
        do_issue(0, 1'b0, 32'h0, 1'b0);
        chk("final_count", m_if.instr_count, 32'd1);
        chk("final_addr", m_if.imem_addr, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
